// File: rtl/fetch_packet_queue_if.sv
// fetch_packet_queue_if
//   Handshake bundle between the instruction frontend, the fetch packet
//   queue and the backend issue stage.
//   Signals:
//     flush      frontend/backend -> queue  drop all queued packets
//     push       frontend -> queue          packet valid this cycle
//     push_data  frontend -> queue          packet payload
//     pop        backend  -> queue          backend ready (not busy)
//     head_valid queue -> backend           queue holds at least one packet
//     head_data  queue -> backend           oldest packet, or NOP when empty
//     full       queue -> frontend          early backpressure
//     count      queue -> observers         current occupancy
//     overflow   queue -> observers         sticky "packet dropped" flag
//   Modports: master (frontend/backend side), slave (the queue).
interface fetch_packet_queue_if #(
  parameter int LINE_WIDTH = 64,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  push;
  logic [LINE_WIDTH-1:0] push_data;
  logic                  pop;
  logic                  head_valid;
  logic [LINE_WIDTH-1:0] head_data;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic                  overflow;

  modport master (
    output flush, push, push_data, pop,
    input  head_valid, head_data, full, count, overflow
  );

  modport slave (
    input  flush, push, push_data, pop,
    output head_valid, head_data, full, count, overflow
  );
endinterface

// File: rtl/fetch_packet_queue.sv
// fetch_packet_queue
//   Decoupling queue between the instruction frontend and the backend issue
//   stage. Accepts one packet per cycle, presents the oldest packet, and
//   substitutes NOP_DATA while empty. `full` rises with SKID free slots still
//   left so packets already in flight can land. `flush` empties the queue.
//   Parameters: DEPTH (>= 2, any value), LINE_WIDTH, SKID (0..DEPTH-1),
//               NOP_DATA (head_data while empty).
//   Ports:
//     clk  core clock, rising edge
//     rst  asynchronous active-low reset
//     bus  fetch_packet_queue_if.slave (flush/push/push_data/pop in;
//          head_valid/head_data/full/count/overflow out)
module fetch_packet_queue #(
  parameter int                    DEPTH      = 4,
  parameter int                    LINE_WIDTH = 64,
  parameter int                    SKID       = 1,
  parameter logic [LINE_WIDTH-1:0] NOP_DATA   = '0
) (
  input logic                 clk,
  input logic                 rst,
  fetch_packet_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH - SKID);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  overflow_reg, overflow_next;
  logic                  do_pop, do_push, wr_en;
  logic [LINE_WIDTH-1:0] slot_data [DEPTH];

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = bus.pop & (count_reg != '0);
  // A push into a full queue still lands when a pop frees a slot this cycle.
  assign do_push = bus.push & ((count_reg < DEPTH_CNT) | do_pop);
  // Flush wins: the push of a flush cycle is never written.
  assign wr_en   = do_push & ~bus.flush;

  // Storage is deliberately not reset; only the pointers/count decide
  // what is visible.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [LINE_WIDTH-1:0] data_reg;
      always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
          data_reg <= bus.push_data;
        end
      end
      assign slot_data[gi] = data_reg;
    end
  endgenerate

  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (bus.flush) begin
      // A push in the flush cycle is discarded silently, so overflow is
      // left alone here.
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      if (do_push && !do_pop) begin
        count_next = count_reg + 1'b1;
      end else if (do_pop && !do_push) begin
        count_next = count_reg - 1'b1;
      end
      if (bus.push && !do_push) begin
        overflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // All outputs decode registered state only; no same-cycle path from
  // push/pop/flush.
  assign bus.head_valid = (count_reg != '0);
  assign bus.head_data  = bus.head_valid ? slot_data[rd_ptr_reg] : NOP_DATA;
  assign bus.full       = (count_reg >= FULL_CNT);
  assign bus.count      = count_reg;
  assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_fetch_packet_queue.sv
// tb_fetch_packet_queue
//   Drives a DEPTH=4 queue (unit 0) and a DEPTH=3 queue (unit 1), both with
//   SKID=1, and compares them against a queue-based reference model.
module tb_fetch_packet_queue;
  localparam int LW = 64;
  localparam logic [LW-1:0] NOP_A = 64'hDEAD_BEEF_0000_0013;
  localparam logic [LW-1:0] NOP_B = 64'h0000_0000_0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_packet_queue_if #(.LINE_WIDTH(LW), .DEPTH(4)) ifa ();
  fetch_packet_queue_if #(.LINE_WIDTH(LW), .DEPTH(3)) ifb ();

  fetch_packet_queue #(.DEPTH(4), .LINE_WIDTH(LW), .SKID(1), .NOP_DATA(NOP_A)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  fetch_packet_queue #(.DEPTH(3), .LINE_WIDTH(LW), .SKID(1), .NOP_DATA(NOP_B)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  logic          obs_valid [2];
  logic [LW-1:0] obs_data  [2];
  logic          obs_full  [2];
  int            obs_count [2];
  logic          obs_ovf   [2];
  assign obs_valid[0] = ifa.head_valid;
  assign obs_valid[1] = ifb.head_valid;
  assign obs_data[0]  = ifa.head_data;
  assign obs_data[1]  = ifb.head_data;
  assign obs_full[0]  = ifa.full;
  assign obs_full[1]  = ifb.full;
  assign obs_count[0] = int'(ifa.count);
  assign obs_count[1] = int'(ifb.count);
  assign obs_ovf[0]   = ifa.overflow;
  assign obs_ovf[1]   = ifb.overflow;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  logic [LW-1:0] qa[$];
  logic [LW-1:0] qb[$];
  bit            ovf_m [2];

  function automatic int m_depth(input int u);
    return (u == 0) ? 4 : 3;
  endfunction
  function automatic logic [LW-1:0] m_nop(input int u);
    return (u == 0) ? NOP_A : NOP_B;
  endfunction
  function automatic int m_size(input int u);
    return (u == 0) ? qa.size() : qb.size();
  endfunction
  function automatic logic [LW-1:0] m_head(input int u);
    if (m_size(u) == 0) return m_nop(u);
    return (u == 0) ? qa[0] : qb[0];
  endfunction
  function automatic bit m_full(input int u);
    return m_size(u) >= m_depth(u) - 1;
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    ovf_m[0] = 1'b0;
    ovf_m[1] = 1'b0;
  endtask

  task automatic model_step(input int u, input bit fl, input bit ps, input bit pp,
                            input logic [LW-1:0] pd);
    logic [LW-1:0] q[$];
    bit popped;
    bit accepted;
    if (u == 0) q = qa; else q = qb;
    if (fl) begin
      q.delete();
    end else begin
      popped   = pp && (q.size() > 0);
      accepted = ps && ((q.size() < m_depth(u)) || popped);
      if (popped) void'(q.pop_front());
      if (accepted) q.push_back(pd);
      if (ps && !accepted) ovf_m[u] = 1'b1;
    end
    if (u == 0) qa = q; else qb = q;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_inputs(input int u, input bit fl, input bit ps, input bit pp,
                            input logic [LW-1:0] pd);
    if (u == 0) begin
      ifa.flush = fl; ifa.push = ps; ifa.pop = pp; ifa.push_data = pd;
    end else begin
      ifb.flush = fl; ifb.push = ps; ifb.pop = pp; ifb.push_data = pd;
    end
  endtask

  task automatic idle_inputs();
    set_inputs(0, 1'b0, 1'b0, 1'b0, '0);
    set_inputs(1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // One clock of traffic on unit u. Returns what the backend sampled in that
  // cycle and what the model says it should have been.
  task automatic drive_cycle(input int u, input bit fl, input bit ps, input bit pp,
                             input logic [LW-1:0] pd,
                             output logic got_valid, output logic [LW-1:0] got_data,
                             output logic exp_valid, output logic [LW-1:0] exp_data);
    @(negedge clk);
    set_inputs(u, fl, ps, pp, pd);
    #1;
    got_valid = obs_valid[u];
    got_data  = obs_data[u];
    exp_valid = (m_size(u) != 0);
    exp_data  = m_head(u);
    $display("[TB] unit%0d flush=%0b push=%0b pop=%0b din=%h head=%h count=%0d",
             u, fl, ps, pp, pd, got_data, obs_count[u]);
    model_step(u, fl, ps, pp, pd);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    for (int u = 0; u < 2; u++) begin
      tests++;
      if (obs_valid[u] !== 1'b0) begin
        fails++; $display("FAIL reset_head_valid unit%0d got %b want 0", u, obs_valid[u]);
      end
      tests++;
      if (obs_data[u] !== m_nop(u)) begin
        fails++; $display("FAIL reset_head_data unit%0d got %h want %h", u, obs_data[u], m_nop(u));
      end
      tests++;
      if (obs_count[u] !== 0) begin
        fails++; $display("FAIL reset_count unit%0d got %0d want 0", u, obs_count[u]);
      end
      tests++;
      if (obs_full[u] !== 1'b0) begin
        fails++; $display("FAIL reset_full unit%0d got %b want 0", u, obs_full[u]);
      end
      tests++;
      if (obs_ovf[u] !== 1'b0) begin
        fails++; $display("FAIL reset_overflow unit%0d got %b want 0", u, obs_ovf[u]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_overflow();
    logic [LW-1:0] pkt [5];
    int            want_cnt [5] = '{1, 2, 3, 4, 4};
    bit            want_full[5] = '{0, 0, 1, 1, 1};
    bit            want_ovf [5] = '{0, 0, 0, 0, 1};
    logic gv, ev;
    logic [LW-1:0] gd, ed;
    apply_reset();
    for (int i = 0; i < 5; i++) pkt[i] = rand_word();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 1'b0, 1'b1, 1'b0, pkt[i], gv, gd, ev, ed);
      tests++;
      if (obs_count[0] !== want_cnt[i]) begin
        fails++; $display("FAIL fill_count push%0d got %0d want %0d", i, obs_count[0], want_cnt[i]);
      end
      tests++;
      if (obs_full[0] !== want_full[i]) begin
        fails++; $display("FAIL fill_full push%0d got %b want %b", i, obs_full[0], want_full[i]);
      end
      tests++;
      if (obs_ovf[0] !== want_ovf[i]) begin
        fails++; $display("FAIL fill_overflow push%0d got %b want %b", i, obs_ovf[0], want_ovf[i]);
      end
      tests++;
      if (obs_data[0] !== pkt[0]) begin
        fails++; $display("FAIL fill_head push%0d got %h want %h", i, obs_data[0], pkt[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 1'b0, 1'b0, 1'b1, '0, gv, gd, ev, ed);
      tests++;
      if (gd !== pkt[i] || gv !== 1'b1) begin
        fails++; $display("FAIL fill_pop_order pop%0d got %h/%b want %h/1", i, gd, gv, pkt[i]);
      end
    end
    tests++;
    if (obs_valid[0] !== 1'b0 || obs_data[0] !== NOP_A) begin
      fails++; $display("FAIL fill_drained got %b/%h want 0/%h", obs_valid[0], obs_data[0], NOP_A);
    end
  endtask

  task automatic test_full_push_pop();
    logic [LW-1:0] pkt [4];
    logic [LW-1:0] x;
    logic [LW-1:0] want [4];
    logic gv, ev;
    logic [LW-1:0] gd, ed;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      pkt[i] = rand_word();
      drive_cycle(0, 1'b0, 1'b1, 1'b0, pkt[i], gv, gd, ev, ed);
    end
    x = rand_word();
    drive_cycle(0, 1'b0, 1'b1, 1'b1, x, gv, gd, ev, ed);
    tests++;
    if (gd !== pkt[0]) begin
      fails++; $display("FAIL fullpp_popped got %h want %h", gd, pkt[0]);
    end
    tests++;
    if (obs_count[0] !== 4 || obs_ovf[0] !== 1'b0) begin
      fails++; $display("FAIL fullpp_state got count=%0d ovf=%b want count=4 ovf=0", obs_count[0], obs_ovf[0]);
    end
    tests++;
    if (obs_data[0] !== pkt[1]) begin
      fails++; $display("FAIL fullpp_head got %h want %h", obs_data[0], pkt[1]);
    end
    want = '{pkt[1], pkt[2], pkt[3], x};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 1'b0, 1'b0, 1'b1, '0, gv, gd, ev, ed);
      tests++;
      if (gd !== want[i]) begin
        fails++; $display("FAIL fullpp_order pop%0d got %h want %h", i, gd, want[i]);
      end
    end
  endtask

  task automatic test_wrap_depth3();
    logic [LW-1:0] pkt [10];
    logic gv, ev;
    logic [LW-1:0] gd, ed;
    apply_reset();
    for (int i = 0; i < 10; i++) pkt[i] = rand_word();
    drive_cycle(1, 1'b0, 1'b1, 1'b0, pkt[0], gv, gd, ev, ed);
    for (int i = 1; i <= 10; i++) begin
      drive_cycle(1, 1'b0, (i < 10), 1'b1, (i < 10) ? pkt[i % 10] : '0, gv, gd, ev, ed);
      tests++;
      if (gd !== pkt[i-1]) begin
        fails++; $display("FAIL wrap_order pop%0d got %h want %h", i - 1, gd, pkt[i-1]);
      end
      tests++;
      if (obs_count[1] !== ((i < 10) ? 1 : 0)) begin
        fails++; $display("FAIL wrap_count step%0d got %0d want %0d", i, obs_count[1], (i < 10) ? 1 : 0);
      end
    end
  endtask

  task automatic test_flush();
    logic [LW-1:0] y, z;
    logic gv, ev;
    logic [LW-1:0] gd, ed;
    apply_reset();
    for (int i = 0; i < 5; i++) drive_cycle(0, 1'b0, 1'b1, 1'b0, rand_word(), gv, gd, ev, ed);
    drive_cycle(0, 1'b0, 1'b0, 1'b1, '0, gv, gd, ev, ed);
    tests++;
    if (obs_count[0] !== 3 || obs_ovf[0] !== 1'b1) begin
      fails++; $display("FAIL flush_setup got count=%0d ovf=%b want count=3 ovf=1", obs_count[0], obs_ovf[0]);
    end
    y = rand_word();
    drive_cycle(0, 1'b1, 1'b1, 1'b1, y, gv, gd, ev, ed);
    tests++;
    if (obs_count[0] !== 0 || obs_valid[0] !== 1'b0 || obs_full[0] !== 1'b0) begin
      fails++; $display("FAIL flush_empty got count=%0d valid=%b full=%b want 0/0/0",
                        obs_count[0], obs_valid[0], obs_full[0]);
    end
    tests++;
    if (obs_data[0] !== NOP_A) begin
      fails++; $display("FAIL flush_nop got %h want %h", obs_data[0], NOP_A);
    end
    tests++;
    if (obs_ovf[0] !== 1'b1) begin
      fails++; $display("FAIL flush_overflow_kept got %b want 1", obs_ovf[0]);
    end
    z = rand_word();
    drive_cycle(0, 1'b0, 1'b1, 1'b0, z, gv, gd, ev, ed);
    drive_cycle(0, 1'b0, 1'b0, 1'b1, '0, gv, gd, ev, ed);
    tests++;
    if (gd !== z) begin
      fails++; $display("FAIL flush_next_packet got %h want %h", gd, z);
    end
  endtask

  task automatic test_pop_empty();
    logic gv, ev;
    logic [LW-1:0] gd, ed;
    apply_reset();
    drive_cycle(1, 1'b0, 1'b0, 1'b1, '0, gv, gd, ev, ed);
    tests++;
    if (gv !== 1'b0 || gd !== NOP_B) begin
      fails++; $display("FAIL pop_empty_head got %b/%h want 0/%h", gv, gd, NOP_B);
    end
    tests++;
    if (obs_count[1] !== 0 || obs_ovf[1] !== 1'b0) begin
      fails++; $display("FAIL pop_empty_state got count=%0d ovf=%b want 0/0", obs_count[1], obs_ovf[1]);
    end
  endtask

  task automatic test_async_reset();
    logic gv, ev;
    logic [LW-1:0] gd, ed;
    apply_reset();
    for (int i = 0; i < 5; i++) drive_cycle(0, 1'b0, 1'b1, 1'b0, rand_word(), gv, gd, ev, ed);
    for (int i = 0; i < 2; i++) drive_cycle(0, 1'b0, 1'b0, 1'b1, '0, gv, gd, ev, ed);
    tests++;
    if (obs_count[0] !== 2 || obs_ovf[0] !== 1'b1) begin
      fails++; $display("FAIL async_setup got count=%0d ovf=%b want 2/1", obs_count[0], obs_ovf[0]);
    end
    // Now one tick after a rising edge; assert reset well before the next one.
    set_inputs(0, 1'b0, 1'b1, 1'b0, rand_word());
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (obs_count[0] !== 0 || obs_valid[0] !== 1'b0 || obs_full[0] !== 1'b0 || obs_ovf[0] !== 1'b0) begin
      fails++; $display("FAIL async_reset got count=%0d valid=%b full=%b ovf=%b want all 0",
                        obs_count[0], obs_valid[0], obs_full[0], obs_ovf[0]);
    end
    tests++;
    if (obs_data[0] !== NOP_A) begin
      fails++; $display("FAIL async_reset_head got %h want %h", obs_data[0], NOP_A);
    end
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic gv, ev;
    logic [LW-1:0] gd, ed;
    int u;
    bit fl, ps, pp;
    for (int blk = 0; blk < 3; blk++) begin
      apply_reset();
      for (int c = 0; c < 120; c++) begin
        u  = int'($urandom_range(0, 1));
        fl = ($urandom_range(0, 19) == 0);
        ps = ($urandom_range(0, 9) < 7);
        pp = ($urandom_range(0, 9) < 5);
        drive_cycle(u, fl, ps, pp, rand_word(), gv, gd, ev, ed);
        tests++;
        if (gv !== ev || gd !== ed) begin
          fails++; $display("FAIL rand_sampled unit%0d cyc%0d got %b/%h want %b/%h", u, c, gv, gd, ev, ed);
        end
        tests++;
        if (obs_count[u] !== m_size(u) || obs_full[u] !== m_full(u) || obs_ovf[u] !== ovf_m[u]) begin
          fails++; $display("FAIL rand_state unit%0d cyc%0d got count=%0d full=%b ovf=%b want %0d/%b/%b",
                            u, c, obs_count[u], obs_full[u], obs_ovf[u], m_size(u), m_full(u), ovf_m[u]);
        end
        tests++;
        if (obs_data[u] !== m_head(u)) begin
          fails++; $display("FAIL rand_head unit%0d cyc%0d got %h want %h", u, c, obs_data[u], m_head(u));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap_depth3();
    test_flush();
    test_pop_empty();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
